// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, keeps at most one request in flight to a
// variable-latency instruction memory, and feeds the IF/ID register every cycle.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        valid_o,
  output logic [1:0]  fsm_state_o
);

  // Handshake: a request transfers on a cycle where imem_req_o & imem_ready_i;
  // exactly one imem_rvalid_i pulse follows each transfer, at least a cycle later.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] buf_inst_q, buf_inst_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic [31:0] out_inst_q, out_inst_d;
  logic        out_valid_q, out_valid_d;

  logic        handshake;
  logic        response;

  always_comb begin
    imem_req_o  = (state_q == S_IDLE) && !buf_valid_q && !redirect_i && !rst_i;
    handshake   = imem_req_o && imem_ready_i;
    response    = (state_q == S_WAIT) && imem_rvalid_i;

    state_d     = state_q;
    pc_d        = pc_q;
    req_pc_d    = req_pc_q;
    buf_pc_d    = buf_pc_q;
    buf_inst_d  = buf_inst_q;
    buf_valid_d = buf_valid_q;
    out_pc_d    = out_pc_q;
    out_inst_d  = out_inst_q;
    out_valid_d = out_valid_q;

    if (redirect_i) begin
      out_pc_d    = 32'h0;
      out_inst_d  = NOP_INST;
      out_valid_d = 1'b0;
      pc_d        = {redirect_pc_i[31:2], 2'b00};
      buf_valid_d = 1'b0;
      // A request still in flight is now wrong-path; if its data lands this
      // very cycle it is simply dropped and nothing remains outstanding.
      if ((state_q != S_IDLE) && !imem_rvalid_i) state_d = S_DROP;
      else                                       state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (handshake) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + 32'd4;
          state_d  = S_WAIT;
        end
        S_WAIT:  if (imem_rvalid_i) state_d = S_IDLE;
        S_DROP:  if (imem_rvalid_i) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase

      if (stall_i) begin
        if (response) begin
          buf_pc_d    = req_pc_q + 32'd4;
          buf_inst_d  = imem_rdata_i;
          buf_valid_d = 1'b1;
        end
      end else if (buf_valid_q) begin
        out_pc_d    = buf_pc_q;
        out_inst_d  = buf_inst_q;
        out_valid_d = 1'b1;
        buf_valid_d = 1'b0;
      end else if (response) begin
        out_pc_d    = req_pc_q + 32'd4;
        out_inst_d  = imem_rdata_i;
        out_valid_d = 1'b1;
      end else begin
        out_pc_d    = 32'h0;
        out_inst_d  = NOP_INST;
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      req_pc_q    <= 32'h0;
      buf_pc_q    <= 32'h0;
      buf_inst_q  <= NOP_INST;
      buf_valid_q <= 1'b0;
      out_pc_q    <= 32'h0;
      out_inst_q  <= NOP_INST;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      buf_pc_q    <= buf_pc_d;
      buf_inst_q  <= buf_inst_d;
      buf_valid_q <= buf_valid_d;
      out_pc_q    <= out_pc_d;
      out_inst_q  <= out_inst_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign imem_addr_o = pc_q;
  assign pc_o        = out_pc_q;
  assign inst_o      = out_inst_q;
  assign valid_o     = out_valid_q;
  assign fsm_state_o = state_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: random traffic against a queue-based fetch model and
// a one-outstanding memory model, plus literal checks including PC wrap.
module tb_if_fetch_unit;

  localparam logic [31:0] XORK = 32'hA5A5_0000;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // main DUT (RESET_PC = 0)
  logic        rst_i = 1'b1, stall_i = 1'b0, redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'h0;
  logic        imem_req_o, imem_ready_i = 1'b0, imem_rvalid_i = 1'b0;
  logic [31:0] imem_addr_o, imem_rdata_i = 32'h0;
  logic [31:0] pc_o, inst_o;
  logic        valid_o;
  logic [1:0]  fsm_state_o;

  if_fetch_unit dut (
    .clk_i(clk), .rst_i(rst_i), .stall_i(stall_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ready_i(imem_ready_i), .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .pc_o(pc_o), .inst_o(inst_o), .valid_o(valid_o), .fsm_state_o(fsm_state_o)
  );

  // second DUT for PC wrap-around
  logic        w_rst = 1'b1, w_ready = 1'b0, w_rvalid = 1'b0, w_req, w_valid;
  logic [31:0] w_rdata = 32'h0, w_addr, w_pc, w_inst;
  logic [1:0]  w_state;

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk_i(clk), .rst_i(w_rst), .stall_i(1'b0), .redirect_i(1'b0),
    .redirect_pc_i(32'h0), .imem_req_o(w_req), .imem_addr_o(w_addr),
    .imem_ready_i(w_ready), .imem_rvalid_i(w_rvalid), .imem_rdata_i(w_rdata),
    .pc_o(w_pc), .inst_o(w_inst), .valid_o(w_valid), .fsm_state_o(w_state)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // fetch model: pending request, wrong-path flag, buffer as a queue
  logic [31:0] m_pc = 32'h0;
  bit          m_pend = 0, m_wrong = 0;
  logic [31:0] m_pend_pc = 32'h0;
  logic [63:0] m_buf[$];
  logic [31:0] m_out_pc = 32'h0, m_out_inst = 32'h0;
  bit          m_out_valid = 0;

  // memory model: at most one request held, countdown to its response
  bit          mem_busy = 0;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = 32'h0;
  int          lat_max = 1;

  // directed-phase scoreboards
  bit          dir_mode = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_addr_q[$];
  bit          hs_now = 0, seen_valid = 0;
  logic [31:0] hs_addr = 32'h0, seen_pc = 32'h0, seen_inst = 32'h0;

  task automatic compare_outputs();
    chk("pc_o", pc_o, m_out_pc);
    chk("inst_o", inst_o, m_out_inst);
    chk("valid_o", {31'h0, valid_o}, {31'h0, m_out_valid});
    seen_valid = valid_o;
    seen_pc    = pc_o;
    seen_inst  = inst_o;
    if (dir_mode && valid_o && exp_q.size() > 0) begin
      logic [31:0] e;
      e = exp_q.pop_front();
      chk("dir_pc", pc_o, e);
      chk("dir_inst", inst_o, (e - 32'd4) ^ XORK);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic rd,
                      input logic [31:0] rpc, input logic rdy);
    bit          exp_req, hs, resp, item_ok;
    logic [63:0] item;
    @(negedge clk);
    compare_outputs();
    rst_i         = r;
    stall_i       = s;
    redirect_i    = rd;
    redirect_pc_i = rpc;
    imem_ready_i  = rdy && !mem_busy;
    imem_rvalid_i = mem_busy && (mem_cnt == 0);
    imem_rdata_i  = imem_rvalid_i ? (mem_addr ^ XORK) : $urandom;
    #1;
    exp_req = !r && !m_pend && (m_buf.size() == 0) && !rd;
    chk("imem_req_o", {31'h0, imem_req_o}, {31'h0, exp_req});
    if (exp_req) chk("imem_addr_o", imem_addr_o, m_pc);
    hs      = exp_req && imem_ready_i;
    hs_now  = hs;
    hs_addr = imem_addr_o;
    if (dir_mode && hs && exp_addr_q.size() > 0) chk("dir_addr", imem_addr_o, exp_addr_q.pop_front());

    // memory side
    if (imem_rvalid_i) mem_busy = 0;
    else if (mem_busy) mem_cnt--;
    if (hs) begin
      mem_busy = 1;
      mem_addr = m_pc;
      mem_cnt  = $urandom_range(lat_max, 1) - 1;
    end

    // fetch side
    if (r) begin
      m_pc = 32'h0; m_pend = 0; m_wrong = 0; m_buf.delete();
      m_out_pc = 32'h0; m_out_inst = 32'h0; m_out_valid = 0;
    end else begin
      resp    = m_pend && imem_rvalid_i;
      item_ok = resp && !m_wrong;
      item    = {m_pend_pc + 32'd4, imem_rdata_i};
      if (rd) begin
        m_out_pc = 32'h0; m_out_inst = 32'h0; m_out_valid = 0;
        m_buf.delete();
        m_pc = {rpc[31:2], 2'b00};
        if (m_pend && !imem_rvalid_i) m_wrong = 1;
        else begin m_pend = 0; m_wrong = 0; end
      end else begin
        if (resp) begin m_pend = 0; m_wrong = 0; end
        if (hs) begin
          m_pend = 1; m_wrong = 0; m_pend_pc = m_pc; m_pc = m_pc + 32'd4;
        end
        if (s) begin
          if (item_ok) m_buf.push_back(item);
        end else if (m_buf.size() > 0) begin
          {m_out_pc, m_out_inst} = m_buf.pop_front();
          m_out_valid = 1;
        end else if (item_ok) begin
          {m_out_pc, m_out_inst} = item;
          m_out_valid = 1;
        end else begin
          m_out_pc = 32'h0; m_out_inst = 32'h0; m_out_valid = 0;
        end
      end
    end
    @(posedge clk);
  endtask

  initial begin
    bit found;
    // reset, then free-run with 1-cycle memory
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    @(negedge clk);
    chk("rst_valid", {31'h0, valid_o}, 32'h0);
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_inst", inst_o, 32'h0);
    dir_mode = 1;
    exp_addr_q = '{32'h0, 32'h4, 32'h8, 32'hC};
    exp_q      = '{32'h4, 32'h8, 32'hC, 32'h10};
    for (int i = 0; i < 9; i++) step(0, 0, 0, 0, 1);
    @(negedge clk);
    compare_outputs();
    chk("dir_addr_left", exp_addr_q.size(), 0);
    chk("dir_pc_left", exp_q.size(), 0);
    dir_mode = 0;

    // redirect to 0x103 while a request waits
    lat_max = 3;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (m_pend && !m_wrong && mem_busy && mem_cnt > 0) found = 1;
      else step(0, 0, 0, 0, 1);
    end
    chk("redir_setup_found", {31'h0, found}, 32'h1);
    step(0, 0, 1, 32'h0000_0103, 1);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(0, 0, 0, 0, 1);
      found = hs_now;
    end
    chk("redir_hs_seen", {31'h0, found}, 32'h1);
    chk("redir_addr", hs_addr, 32'h0000_0100);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(0, 0, 0, 0, 1);
      found = seen_valid;
    end
    chk("redir_deliver_seen", {31'h0, found}, 32'h1);
    chk("redir_pc", seen_pc, 32'h0000_0104);
    chk("redir_inst", seen_inst, 32'hA5A5_0100);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(79, 0) == 0), ($urandom_range(3, 0) == 0),
           ($urandom_range(7, 0) == 0), $urandom, ($urandom_range(3, 0) != 0));
    end
    @(negedge clk);
    compare_outputs();
    rst_i = 1'b1;

    // PC wrap on the second instance
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    w_rst = 1'b0; w_ready = 1'b1;
    #1;
    chk("wrap_req", {31'h0, w_req}, 32'h1);
    chk("wrap_addr0", w_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    w_rvalid = 1'b1; w_rdata = 32'hFFFF_FFFC ^ XORK;
    #1;
    chk("wrap_req_wait", {31'h0, w_req}, 32'h0);
    @(negedge clk);
    w_rvalid = 1'b0;
    #1;
    chk("wrap_valid", {31'h0, w_valid}, 32'h1);
    chk("wrap_pc", w_pc, 32'h0000_0000);
    chk("wrap_inst", w_inst, 32'h5A5A_FFFC);
    chk("wrap_addr1", w_addr, 32'h0000_0000);
    chk("wrap_req1", {31'h0, w_req}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
